// File: rtl/fetch_sequencer_if.sv
// Control/decode bundle between the fetch sequencer and the rest of the 9-bit core.
// The master side drives decode, loader and start; the slave side is the sequencer.
interface fetch_sequencer_if #(
   parameter int PC_W  = 10,
   parameter int CNT_W = 16
);
   logic              Start;
   logic [PC_W-1:0]   StartAddr;
   logic              Jump;
   logic              BranchEn;
   logic              Zero;
   logic              LoadInst;
   logic              Ack;
   logic [2:0]        TargSel;
   logic              LutWrEn;
   logic [2:0]        LutWrIdx;
   logic [PC_W-1:0]   LutWrData;
   logic [PC_W-1:0]   ProgCtr;
   logic              Commit;
   logic              Busy;
   logic              Done;
   logic [CNT_W-1:0]  CycleCount;

   modport master (
      output Start, StartAddr, Jump, BranchEn, Zero, LoadInst, Ack, TargSel,
             LutWrEn, LutWrIdx, LutWrData,
      input  ProgCtr, Commit, Busy, Done, CycleCount
   );

   modport slave (
      input  Start, StartAddr, Jump, BranchEn, Zero, LoadInst, Ack, TargSel,
             LutWrEn, LutWrIdx, LutWrData,
      output ProgCtr, Commit, Busy, Done, CycleCount
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter owner: sequences fetch, commit, multi-cycle load wait and halt,
// and holds the 8-entry branch/jump target table.
module fetch_sequencer #(
   parameter int PC_W    = 10,
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   fetch_sequencer_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALT} state_t;

   localparam logic [2:0] LAT     = 3'(MEM_LAT);
   localparam bit         HAS_LAT = (MEM_LAT != 0);

   state_t            state_reg, state_next;
   logic [PC_W-1:0]   pc_reg, pc_next;
   logic              done_reg, done_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
   logic [2:0]        wait_reg, wait_next;
   logic              commit, busy;
   logic [PC_W-1:0]   table_reg [8];
   logic [7:0]        wr_sel;
   logic [PC_W-1:0]   target_pc;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_wr_sel
         assign wr_sel[gi] = bus.LutWrEn && (bus.LutWrIdx == 3'(gi));
      end
   endgenerate

   // Reads see the pre-edge contents, so a same-cycle write never forwards.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < 8; i++) begin
         if (Reset)
            table_reg[i] <= '0;
         else if (wr_sel[i])
            table_reg[i] <= bus.LutWrData;
      end
   end

   always_comb begin
      target_pc = pc_reg + PC_W'(1);
      if (bus.Jump || (bus.BranchEn && bus.Zero))
         target_pc = table_reg[bus.TargSel];
   end

   assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      done_next  = done_reg;
      cnt_next   = cnt_reg;
      wait_next  = wait_reg;
      commit     = 1'b0;
      busy       = 1'b0;
      case (state_reg)
         S_IDLE, S_HALT: begin
            if (bus.Start) begin
               pc_next    = bus.StartAddr;
               cnt_next   = '0;
               done_next  = 1'b0;
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            busy     = 1'b1;
            cnt_next = cnt_inc;
            if (bus.Ack) begin
               commit     = 1'b1;
               done_next  = 1'b1;
               state_next = S_HALT;
            end else if (bus.LoadInst && HAS_LAT) begin
               wait_next  = LAT;
               state_next = S_WAIT;
            end else begin
               commit  = 1'b1;
               pc_next = target_pc;
            end
         end
         S_WAIT: begin
            busy     = 1'b1;
            cnt_next = cnt_inc;
            if (wait_reg > 3'd1) begin
               wait_next = wait_reg - 3'd1;
            end else begin
               // Last cycle of the load: decode is valid again and the load retires.
               commit     = 1'b1;
               pc_next    = target_pc;
               wait_next  = '0;
               state_next = S_RUN;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg <= S_IDLE;
         pc_reg    <= '0;
         done_reg  <= 1'b0;
         cnt_reg   <= '0;
         wait_reg  <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         done_reg  <= done_next;
         cnt_reg   <= cnt_next;
         wait_reg  <= wait_next;
      end
   end

   assign bus.ProgCtr    = pc_reg;
   assign bus.Done       = done_reg;
   assign bus.CycleCount = cnt_reg;
   assign bus.Commit     = commit & ~Reset;
   assign bus.Busy       = busy & ~Reset;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one DUT with a 2-cycle load latency and one
// with single-cycle loads, sharing clock and reset.
module tb_fetch_sequencer;
   logic Clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   passes = 0;

   always #5 Clk = ~Clk;

   fetch_sequencer_if #(.PC_W(10), .CNT_W(16)) bus  ();
   fetch_sequencer_if #(.PC_W(10), .CNT_W(16)) bus0 ();

   fetch_sequencer #(.PC_W(10), .MEM_LAT(2), .CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .bus(bus.slave));
   fetch_sequencer #(.PC_W(10), .MEM_LAT(0), .CNT_W(16)) dut0 (
      .Clk(Clk), .Reset(Reset), .bus(bus0.slave));

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic clr();
      bus.Start = 0; bus.StartAddr = '0; bus.Jump = 0; bus.BranchEn = 0; bus.Zero = 0;
      bus.LoadInst = 0; bus.Ack = 0; bus.TargSel = '0; bus.LutWrEn = 0;
      bus.LutWrIdx = '0; bus.LutWrData = '0;
      bus0.Start = 0; bus0.StartAddr = '0; bus0.Jump = 0; bus0.BranchEn = 0; bus0.Zero = 0;
      bus0.LoadInst = 0; bus0.Ack = 0; bus0.TargSel = '0; bus0.LutWrEn = 0;
      bus0.LutWrIdx = '0; bus0.LutWrData = '0;
   endtask

   task automatic start(input logic [9:0] addr);
      clr(); bus.Start = 1; bus.StartAddr = addr; cyc(); clr();
   endtask

   task automatic test_reset();
      clr(); Reset = 1; cyc(); cyc(); #1;
      checks++; if (bus.ProgCtr !== 10'd0) $display("FAIL reset_pc got %0d exp 0", bus.ProgCtr); else passes++;
      checks++; if ({bus.Done, bus.Commit, bus.Busy} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {bus.Done, bus.Commit, bus.Busy}); else passes++;
      checks++; if (bus.CycleCount !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", bus.CycleCount); else passes++;
      Reset = 0; cyc();
      $display("reset: pc=%0d done=%b", bus.ProgCtr, bus.Done);
   endtask

   task automatic test_basic();
      start(10'd5);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (bus.ProgCtr !== 10'(5 + i)) $display("FAIL basic_pc got %0d exp %0d", bus.ProgCtr, 5 + i); else passes++;
         checks++; if ({bus.Commit, bus.Busy} !== 2'b11) $display("FAIL basic_commit got %b exp 11", {bus.Commit, bus.Busy}); else passes++;
         $display("basic: pc=%0d commit=%b", bus.ProgCtr, bus.Commit);
         cyc();
      end
      bus.Ack = 1; #1;
      checks++; if (bus.ProgCtr !== 10'd9 || bus.Commit !== 1'b1 || bus.Done !== 1'b0) $display("FAIL basic_ack got pc=%0d c=%b d=%b exp pc=9 c=1 d=0", bus.ProgCtr, bus.Commit, bus.Done); else passes++;
      cyc(); clr(); #1;
      checks++; if ({bus.Done, bus.Busy, bus.Commit} !== 3'b100) $display("FAIL basic_halt got %b exp 100", {bus.Done, bus.Busy, bus.Commit}); else passes++;
      checks++; if (bus.CycleCount !== 16'd5) $display("FAIL basic_cnt got %0d exp 5", bus.CycleCount); else passes++;
      checks++; if (bus.ProgCtr !== 10'd9) $display("FAIL basic_halt_pc got %0d exp 9", bus.ProgCtr); else passes++;
      cyc();
      checks++; if (bus.CycleCount !== 16'd5 || bus.Done !== 1'b1) $display("FAIL halt_frozen got cnt=%0d d=%b exp 5 1", bus.CycleCount, bus.Done); else passes++;
   endtask

   task automatic test_branch();
      clr(); bus.LutWrEn = 1; bus.LutWrIdx = 3'd3; bus.LutWrData = 10'd40; cyc();
      start(10'd10);
      bus.BranchEn = 1; bus.TargSel = 3'd3; bus.Zero = 0; cyc(); #1;
      checks++; if (bus.ProgCtr !== 10'd11) $display("FAIL br_nt got %0d exp 11", bus.ProgCtr); else passes++;
      bus.Zero = 1; cyc(); #1;
      checks++; if (bus.ProgCtr !== 10'd40) $display("FAIL br_t got %0d exp 40", bus.ProgCtr); else passes++;
      clr(); cyc(); #1;
      checks++; if (bus.ProgCtr !== 10'd41) $display("FAIL br_seq got %0d exp 41", bus.ProgCtr); else passes++;
      bus.Jump = 1; bus.BranchEn = 1; bus.Zero = 0; bus.TargSel = 3'd3; cyc(); #1;
      checks++; if (bus.ProgCtr !== 10'd40) $display("FAIL jump got %0d exp 40", bus.ProgCtr); else passes++;
      $display("branch: pc=%0d", bus.ProgCtr);
      clr(); bus.Ack = 1; cyc(); clr();
   endtask

   task automatic test_load();
      logic [2:0] cm;
      start(10'd20);
      bus.LoadInst = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         cm[i] = bus.Commit;
         checks++; if (bus.ProgCtr !== 10'd20) $display("FAIL load_hold got %0d exp 20", bus.ProgCtr); else passes++;
         cyc();
      end
      checks++; if (cm !== 3'b100) $display("FAIL load_commit got %b exp 100", cm); else passes++;
      clr(); #1;
      checks++; if (bus.ProgCtr !== 10'd21 || bus.CycleCount !== 16'd3) $display("FAIL load_after got pc=%0d cnt=%0d exp 21 3", bus.ProgCtr, bus.CycleCount); else passes++;
      bus.Ack = 1; cyc(); clr();
      bus0.Start = 1; bus0.StartAddr = 10'd20; cyc(); clr();
      bus0.LoadInst = 1; #1;
      checks++; if (bus0.Commit !== 1'b1) $display("FAIL load0_commit got %b exp 1", bus0.Commit); else passes++;
      cyc(); clr(); #1;
      checks++; if (bus0.ProgCtr !== 10'd21) $display("FAIL load0_pc got %0d exp 21", bus0.ProgCtr); else passes++;
      $display("load: lat2 pc=%0d lat0 pc=%0d", bus.ProgCtr, bus0.ProgCtr);
      bus0.Ack = 1; cyc(); clr();
   endtask

   task automatic test_wrap();
      start(10'd1023);
      #1;
      checks++; if (bus.ProgCtr !== 10'd1023) $display("FAIL wrap_start got %0d exp 1023", bus.ProgCtr); else passes++;
      cyc(); #1;
      checks++; if (bus.ProgCtr !== 10'd0) $display("FAIL wrap got %0d exp 0", bus.ProgCtr); else passes++;
      $display("wrap: pc=%0d", bus.ProgCtr);
      bus.Ack = 1; cyc(); clr();
   endtask

   task automatic test_reset_in_wait();
      start(10'd50);
      bus.LoadInst = 1; cyc(); #1;
      checks++; if (bus.Busy !== 1'b1 || bus.ProgCtr !== 10'd50 || bus.Commit !== 1'b0) $display("FAIL wait_state got b=%b pc=%0d c=%b exp 1 50 0", bus.Busy, bus.ProgCtr, bus.Commit); else passes++;
      Reset = 1; cyc(); Reset = 0; clr(); #1;
      checks++; if (bus.ProgCtr !== 10'd0 || {bus.Busy, bus.Commit, bus.Done} !== 3'b000) $display("FAIL rst_wait got pc=%0d f=%b exp 0 000", bus.ProgCtr, {bus.Busy, bus.Commit, bus.Done}); else passes++;
      cyc(); #1;
      checks++; if (bus.ProgCtr !== 10'd0 || bus.Busy !== 1'b0) $display("FAIL rst_idle got pc=%0d b=%b exp 0 0", bus.ProgCtr, bus.Busy); else passes++;
      start(10'd60);
      bus.Jump = 1; bus.TargSel = 3'd3; cyc(); #1;
      checks++; if (bus.ProgCtr !== 10'd0) $display("FAIL rst_table got %0d exp 0", bus.ProgCtr); else passes++;
      $display("reset_in_wait: pc=%0d", bus.ProgCtr);
      clr(); bus.Ack = 1; cyc(); clr();
   endtask

   task automatic test_restart();
      start(10'd30);
      bus.Start = 1; bus.StartAddr = 10'd99; cyc(); #1;
      checks++; if (bus.ProgCtr !== 10'd31 || bus.CycleCount !== 16'd1) $display("FAIL start_in_run got pc=%0d cnt=%0d exp 31 1", bus.ProgCtr, bus.CycleCount); else passes++;
      clr(); bus.Ack = 1; cyc(); clr();
      bus.Start = 1; bus.StartAddr = 10'd7; #1;
      checks++; if (bus.Done !== 1'b1 || bus.CycleCount !== 16'd2) $display("FAIL halt_pre got d=%b cnt=%0d exp 1 2", bus.Done, bus.CycleCount); else passes++;
      cyc(); clr(); #1;
      checks++; if (bus.Done !== 1'b0 || bus.ProgCtr !== 10'd7 || bus.CycleCount !== 16'd0 || bus.Busy !== 1'b1) $display("FAIL restart got d=%b pc=%0d cnt=%0d b=%b exp 0 7 0 1", bus.Done, bus.ProgCtr, bus.CycleCount, bus.Busy); else passes++;
      bus.LutWrEn = 1; bus.LutWrIdx = 3'd3; bus.LutWrData = 10'd77; bus.Jump = 1; bus.TargSel = 3'd3; cyc(); #1;
      checks++; if (bus.ProgCtr !== 10'd0) $display("FAIL wr_same_cycle got %0d exp 0", bus.ProgCtr); else passes++;
      bus.LutWrEn = 0; cyc(); #1;
      checks++; if (bus.ProgCtr !== 10'd77) $display("FAIL wr_after got %0d exp 77", bus.ProgCtr); else passes++;
      $display("restart: pc=%0d", bus.ProgCtr);
      clr(); bus.Ack = 1; cyc(); clr();
   endtask

   initial begin
      clr();
      Reset = 1;
      #1;
      test_reset();
      test_basic();
      test_branch();
      test_load();
      test_wrap();
      test_reset_in_wait();
      test_restart();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
